// File: rtl/fft_pkg.sv
// Shared types and arithmetic helpers for the radix-2 DIT FFT stage engine.
package fft_pkg;

   localparam int CPLX_W = 16;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} fft_state_t;

   typedef struct packed {
      logic signed [CPLX_W-1:0] re;
      logic signed [CPLX_W-1:0] im;
   } cplx_t;

   typedef struct packed {
      logic [31:0] i0;
      logic [31:0] i1;
      logic [31:0] k;
   } bfly_idx_t;

   function automatic int log2n(input int n);
      return $clog2(n);
   endfunction

   // Round half up, then arithmetic shift right by sh (sh >= 1).
   function automatic longint round_shift(input longint v, input int sh);
      return (v + (longint'(1) << (sh - 1))) >>> sh;
   endfunction

   function automatic longint saturate(input longint v, input int dw);
      longint hi;
      longint lo;
      hi = (longint'(1) << (dw - 1)) - 1;
      lo = -(longint'(1) << (dw - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // Butterfly b of stage s: operand pair (i0, i1) and twiddle index k.
   function automatic bfly_idx_t bfly_index(input int b, input int s, input int logn);
      bfly_idx_t r;
      int h;
      int j;
      int i0;
      h    = 1 << s;
      j    = b & (h - 1);
      i0   = ((b >> s) << (s + 1)) + j;
      r.i0 = i0;
      r.i1 = i0 + h;
      r.k  = j << (logn - 1 - s);
      return r;
   endfunction

endpackage

// File: rtl/fft_bfly_lane.sv
// Two-stage complex butterfly lane: twiddle multiply, then add/sub, optional
// halving and saturation. Operand indices travel with the data.
module fft_bfly_lane
   import fft_pkg::*;
#(
   parameter int DW   = 16,
   parameter int FRAC = 14,
   parameter int IW   = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic [IW-1:0]   in_i0,
   input  logic [IW-1:0]   in_i1,
   input  logic [2*DW-1:0] in_a,
   input  logic [2*DW-1:0] in_b,
   input  logic [2*DW-1:0] tw,
   input  logic            scale_en,
   output logic            out_valid,
   output logic [IW-1:0]   out_i0,
   output logic [IW-1:0]   out_i1,
   output logic [2*DW-1:0] out_y0,
   output logic [2*DW-1:0] out_y1
);

   // Product of a DW-bit value and a unit-magnitude twiddle needs DW+3 bits.
   localparam int TW = DW + 3;

   logic                 s0_valid;
   logic [IW-1:0]        s0_i0;
   logic [IW-1:0]        s0_i1;
   logic [2*DW-1:0]      s0_a;
   logic [2*DW-1:0]      s0_b;
   logic                 s1_valid;
   logic [IW-1:0]        s1_i0;
   logic [IW-1:0]        s1_i1;
   logic [2*DW-1:0]      s1_a;
   logic signed [TW-1:0] s1_t_re;
   logic signed [TW-1:0] s1_t_im;
   longint               t_re;
   longint               t_im;

   function automatic logic [DW-1:0] post(input longint v, input logic sc);
      longint r;
      r = sc ? round_shift(v, 1) : v;
      return DW'(saturate(r, DW));
   endfunction

   always_comb begin
      t_re = round_shift(longint'($signed(s0_b[2*DW-1:DW])) * longint'($signed(tw[2*DW-1:DW]))
                       - longint'($signed(s0_b[DW-1:0])) * longint'($signed(tw[DW-1:0])), FRAC);
      t_im = round_shift(longint'($signed(s0_b[2*DW-1:DW])) * longint'($signed(tw[DW-1:0]))
                       + longint'($signed(s0_b[DW-1:0])) * longint'($signed(tw[2*DW-1:DW])), FRAC);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s0_valid <= 1'b0;
         s0_i0    <= '0;
         s0_i1    <= '0;
         s0_a     <= '0;
         s0_b     <= '0;
         s1_valid <= 1'b0;
         s1_i0    <= '0;
         s1_i1    <= '0;
         s1_a     <= '0;
         s1_t_re  <= '0;
         s1_t_im  <= '0;
      end else begin
         s0_valid <= in_valid;
         s0_i0    <= in_i0;
         s0_i1    <= in_i1;
         s0_a     <= in_a;
         s0_b     <= in_b;
         s1_valid <= s0_valid;
         s1_i0    <= s0_i0;
         s1_i1    <= s0_i1;
         s1_a     <= s0_a;
         s1_t_re  <= TW'(t_re);
         s1_t_im  <= TW'(t_im);
      end
   end

   always_comb begin
      out_valid = s1_valid;
      out_i0    = s1_i0;
      out_i1    = s1_i1;
      out_y0    = {post(longint'($signed(s1_a[2*DW-1:DW])) + longint'(s1_t_re), scale_en),
                   post(longint'($signed(s1_a[DW-1:0])) + longint'(s1_t_im), scale_en)};
      out_y1    = {post(longint'($signed(s1_a[2*DW-1:DW])) - longint'(s1_t_re), scale_en),
                   post(longint'($signed(s1_a[DW-1:0])) - longint'(s1_t_im), scale_en)};
   end

endmodule

// File: rtl/fft_stage_seq.sv
// One radix-2 DIT butterfly stage over an N-point frame, time-multiplexed
// over P lanes, with in-place write-back into an internal frame buffer.
module fft_stage_seq
   import fft_pkg::*;
#(
   parameter int N    = 32,
   parameter int P    = 4,
   parameter int DW   = 16,
   parameter int FRAC = 14
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [$clog2(N)-1:0]           stage,
   input  logic                           scale_en,
   input  logic [N*2*DW-1:0]              din,
   output logic                           busy,
   output logic                           done,
   output logic                           err,
   output logic [N*2*DW-1:0]              dout,
   output logic [P*($clog2(N)-1)-1:0]     tw_addr,
   input  logic [P*2*DW-1:0]              tw_data
);

   localparam int LOGN = log2n(N);
   localparam int KW   = LOGN - 1;
   localparam int C    = N / (2 * P);
   localparam int CW   = (C > 1) ? $clog2(C) : 1;
   localparam logic [LOGN-1:0] LOGN_V = LOGN'(LOGN);

   fft_state_t       state;
   logic [CW-1:0]    cnt;
   logic [LOGN-1:0]  stage_q;
   logic             scale_q;
   logic [2*DW-1:0]  frame_q  [N];
   logic [2*DW-1:0]  next_buf [N];
   logic             issue_valid;

   logic [LOGN-1:0]  rd_i0 [P];
   logic [LOGN-1:0]  rd_i1 [P];
   logic [2*DW-1:0]  rd_a  [P];
   logic [2*DW-1:0]  rd_b  [P];
   logic             wb_valid [P];
   logic [LOGN-1:0]  wb_i0 [P];
   logic [LOGN-1:0]  wb_i1 [P];
   logic [2*DW-1:0]  wb_y0 [P];
   logic [2*DW-1:0]  wb_y1 [P];

   assign issue_valid = (state == RUN);

   always_comb begin
      bfly_idx_t idx;
      tw_addr = '0;
      for (int p = 0; p < P; p++) begin
         idx      = bfly_index(int'(cnt) * P + p, int'(stage_q), LOGN);
         rd_i0[p] = LOGN'(idx.i0);
         rd_i1[p] = LOGN'(idx.i1);
         rd_a[p]  = frame_q[rd_i0[p]];
         rd_b[p]  = frame_q[rd_i1[p]];
         if (issue_valid) tw_addr[p*KW +: KW] = KW'(idx.k);
      end
   end

   for (genvar p = 0; p < P; p++) begin : g_lane
      fft_bfly_lane #(.DW(DW), .FRAC(FRAC), .IW(LOGN)) u_lane (
         .clk       (clk),
         .reset     (reset),
         .in_valid  (issue_valid),
         .in_i0     (rd_i0[p]),
         .in_i1     (rd_i1[p]),
         .in_a      (rd_a[p]),
         .in_b      (rd_b[p]),
         .tw        (tw_data[p*2*DW +: 2*DW]),
         .scale_en  (scale_q),
         .out_valid (wb_valid[p]),
         .out_i0    (wb_i0[p]),
         .out_i1    (wb_i1[p]),
         .out_y0    (wb_y0[p]),
         .out_y1    (wb_y1[p])
      );
   end

   // Each index is owned by one butterfly per stage, so lane writes never collide.
   always_comb begin
      next_buf = frame_q;
      for (int p = 0; p < P; p++) begin
         if (wb_valid[p]) begin
            next_buf[wb_i0[p]] = wb_y0[p];
            next_buf[wb_i1[p]] = wb_y1[p];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         stage_q <= '0;
         scale_q <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         dout    <= '0;
         for (int i = 0; i < N; i++) frame_q[i] <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (stage < LOGN_V) begin
                     for (int i = 0; i < N; i++) frame_q[i] <= din[i*2*DW +: 2*DW];
                     stage_q <= stage;
                     scale_q <= scale_en;
                     busy    <= 1'b1;
                     cnt     <= '0;
                     state   <= RUN;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            RUN: begin
               for (int i = 0; i < N; i++) frame_q[i] <= next_buf[i];
               if (cnt == CW'(C - 1)) begin
                  cnt   <= '0;
                  state <= DRAIN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DRAIN: begin
               for (int i = 0; i < N; i++) frame_q[i] <= next_buf[i];
               // The final lane write-back lands on this edge; publish it as well.
               if (cnt == CW'(1)) begin
                  for (int i = 0; i < N; i++) dout[i*2*DW +: 2*DW] <= next_buf[i];
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_stage_seq.sv
// Self-checking bench for fft_stage_seq: directed cases plus random frames
// checked against a group/offset formulation of one radix-2 DIT stage.
module tb_fft_stage_seq;
   import fft_pkg::*;

   localparam int N    = 32;
   localparam int P    = 4;
   localparam int DW   = 16;
   localparam int FRAC = 14;
   localparam int LOGN = 5;
   localparam int KW   = LOGN - 1;
   localparam int C    = N / (2 * P);
   localparam int LAT  = C + 2;

   logic                clk = 1'b0;
   logic                reset;
   logic                start;
   logic [LOGN-1:0]     stage;
   logic                scale_en;
   logic [N*2*DW-1:0]   din;
   logic                busy;
   logic                done;
   logic                err;
   logic [N*2*DW-1:0]   dout;
   logic [P*KW-1:0]     tw_addr;
   logic [P*2*DW-1:0]   tw_data;

   int rom_re [N/2];
   int rom_im [N/2];
   int xr [N];
   int xi [N];
   int er [N];
   int ei [N];
   int tests = 0;
   int fails = 0;

   fft_stage_seq #(.N(N), .P(P), .DW(DW), .FRAC(FRAC)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .stage    (stage),
      .scale_en (scale_en),
      .din      (din),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .dout     (dout),
      .tw_addr  (tw_addr),
      .tw_data  (tw_data)
   );

   always #5 clk = ~clk;

   // Synchronous twiddle ROM: data follows the address by one cycle.
   always @(posedge clk) begin
      for (int p = 0; p < P; p++)
         tw_data[p*2*DW +: 2*DW] <= {16'(rom_re[tw_addr[p*KW +: KW]]), 16'(rom_im[tw_addr[p*KW +: KW]])};
   end

   function automatic int dout_re(input int i);
      return int'($signed(dout[i*2*DW+DW +: DW]));
   endfunction

   function automatic int dout_im(input int i);
      return int'($signed(dout[i*2*DW +: DW]));
   endfunction

   function automatic int post(input longint v, input bit sc);
      longint r;
      r = sc ? ((v + 1) >>> 1) : v;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      return int'(r);
   endfunction

   task automatic clear_frame();
      for (int i = 0; i < N; i++) begin
         xr[i] = 0;
         xi[i] = 0;
      end
   endtask

   task automatic random_frame();
      for (int i = 0; i < N; i++) begin
         xr[i] = int'($urandom_range(0, 65535)) - 32768;
         xi[i] = int'($urandom_range(0, 65535)) - 32768;
      end
   endtask

   // Stage s pairs elements h = 2^s apart inside groups of 2h; offset j uses W_N^(j*N/2h).
   task automatic compute_model(input int s, input bit sc);
      int h, span, i0, i1;
      longint wr, wi, tr, ti;
      h    = 1 << s;
      span = N / (2 * h);
      for (int g = 0; g < N; g += 2 * h) begin
         for (int j = 0; j < h; j++) begin
            i0 = g + j;
            i1 = i0 + h;
            wr = rom_re[j * span];
            wi = rom_im[j * span];
            tr = (longint'(xr[i1]) * wr - longint'(xi[i1]) * wi + 8192) >>> 14;
            ti = (longint'(xr[i1]) * wi + longint'(xi[i1]) * wr + 8192) >>> 14;
            er[i0] = post(longint'(xr[i0]) + tr, sc);
            ei[i0] = post(longint'(xi[i0]) + ti, sc);
            er[i1] = post(longint'(xr[i0]) - tr, sc);
            ei[i1] = post(longint'(xi[i0]) - ti, sc);
         end
      end
   endtask

   task automatic load_frame();
      for (int i = 0; i < N; i++) din[i*2*DW +: 2*DW] = {16'(xr[i]), 16'(xi[i])};
   endtask

   function automatic int frame_errors(output int first);
      int n;
      n = 0;
      first = -1;
      for (int i = 0; i < N; i++) begin
         if (dout_re(i) !== er[i] || dout_im(i) !== ei[i]) begin
            if (first < 0) first = i;
            n++;
         end
      end
      return n;
   endfunction

   task automatic run_stage(input int s, input bit sc, output int lat,
                            output logic [P*KW-1:0] tw0, output logic busy0);
      load_frame();
      stage    = LOGN'(s);
      scale_en = sc;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      tw0   = tw_addr;
      busy0 = busy;
      lat   = -1;
      for (int e = 1; e <= 40 && lat < 0; e++) begin
         @(posedge clk);
         #1;
         if (done) lat = e;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b, expected 0", done); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b, expected 0", err); end
      tests++; if (dout !== '0) begin fails++; $display("FAIL reset_dout: got nonzero frame, expected 0"); end
      tests++; if (tw_addr !== '0) begin fails++; $display("FAIL reset_tw_addr: got %h, expected 0", tw_addr); end
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic(input bit sc);
      int lat, nerr, first;
      logic [P*KW-1:0] tw0;
      logic busy0;
      clear_frame();
      xr[0] = 1000;
      xr[1] = 200;
      compute_model(0, sc);
      run_stage(0, sc, lat, tw0, busy0);
      tests++; if (lat !== LAT) begin fails++; $display("FAIL basic_latency sc=%0d: got %0d, expected %0d", sc, lat, LAT); end
      tests++; if (busy0 !== 1'b1) begin fails++; $display("FAIL basic_busy sc=%0d: got %b, expected 1", sc, busy0); end
      tests++;
      if (dout_re(0) !== (sc ? 600 : 1200) || dout_re(1) !== (sc ? 400 : 800) || dout_im(0) !== 0 || dout_im(1) !== 0) begin
         fails++;
         $display("FAIL basic_values sc=%0d: got (%0d,%0d) (%0d,%0d), expected (%0d,0) (%0d,0)", sc,
                  dout_re(0), dout_im(0), dout_re(1), dout_im(1), sc ? 600 : 1200, sc ? 400 : 800);
      end
      nerr = frame_errors(first);
      tests++; if (nerr !== 0) begin fails++; $display("FAIL basic_frame sc=%0d: %0d bad elements, first %0d got (%0d,%0d) expected (%0d,%0d)", sc, nerr, first, dout_re(first), dout_im(first), er[first], ei[first]); end
   endtask

   task automatic test_saturation();
      int lat;
      logic [P*KW-1:0] tw0;
      logic busy0;
      clear_frame();
      xr[0] = 32767;
      xr[1] = 32767;
      run_stage(0, 1'b0, lat, tw0, busy0);
      tests++; if (dout_re(0) !== 32767 || dout_re(1) !== 0) begin fails++; $display("FAIL sat_pos: got %0d/%0d, expected 32767/0", dout_re(0), dout_re(1)); end
      xr[0] = -32768;
      xr[1] = -32768;
      run_stage(0, 1'b0, lat, tw0, busy0);
      tests++; if (dout_re(0) !== -32768 || dout_re(1) !== 0) begin fails++; $display("FAIL sat_neg: got %0d/%0d, expected -32768/0", dout_re(0), dout_re(1)); end
   endtask

   task automatic test_twiddle();
      int lat, nerr, first;
      logic [P*KW-1:0] tw0;
      logic busy0;
      clear_frame();
      xr[16] = 1000;
      xr[17] = 1000;
      compute_model(4, 1'b0);
      run_stage(4, 1'b0, lat, tw0, busy0);
      tests++; if (tw0 !== 16'h3210) begin fails++; $display("FAIL tw_addr_cycle0: got %h, expected 3210", tw0); end
      tests++; if (lat !== LAT) begin fails++; $display("FAIL twiddle_latency: got %0d, expected %0d", lat, LAT); end
      tests++;
      if (dout_re(0) !== 1000 || dout_re(16) !== -1000 || dout_re(1) !== 981 || dout_im(1) !== -195 ||
          dout_re(17) !== -981 || dout_im(17) !== 195) begin
         fails++;
         $display("FAIL twiddle_values: got [0]=%0d [16]=%0d [1]=(%0d,%0d) [17]=(%0d,%0d), expected 1000 -1000 (981,-195) (-981,195)",
                  dout_re(0), dout_re(16), dout_re(1), dout_im(1), dout_re(17), dout_im(17));
      end
      nerr = frame_errors(first);
      tests++; if (nerr !== 0) begin fails++; $display("FAIL twiddle_frame: %0d bad elements, first %0d got (%0d,%0d) expected (%0d,%0d)", nerr, first, dout_re(first), dout_im(first), er[first], ei[first]); end
   endtask

   task automatic test_random();
      int lat, nerr, first, s;
      bit sc;
      logic [P*KW-1:0] tw0;
      logic busy0;
      for (int t = 0; t < 10; t++) begin
         random_frame();
         s  = int'($urandom_range(0, LOGN - 1));
         sc = 1'($urandom_range(0, 1));
         compute_model(s, sc);
         run_stage(s, sc, lat, tw0, busy0);
         tests++; if (lat !== LAT) begin fails++; $display("FAIL random_latency #%0d: got %0d, expected %0d", t, lat, LAT); end
         nerr = frame_errors(first);
         tests++; if (nerr !== 0) begin fails++; $display("FAIL random_frame #%0d s=%0d sc=%0d: %0d bad, first %0d got (%0d,%0d) expected (%0d,%0d)", t, s, sc, nerr, first, dout_re(first), dout_im(first), er[first], ei[first]); end
      end
   endtask

   task automatic test_hold_start();
      int dones, errs, first_done, nerr, first;
      dones = 0;
      errs = 0;
      first_done = -1;
      random_frame();
      compute_model(1, 1'b0);
      load_frame();
      stage    = LOGN'(1);
      scale_en = 1'b0;
      start    = 1'b1;
      @(posedge clk);
      #1;
      for (int e = 1; e <= 12; e++) begin
         @(posedge clk);
         #1;
         if (done) begin
            dones++;
            if (first_done < 0) first_done = e;
         end
         if (err) errs++;
         if (e == 5) start = 1'b0;
      end
      tests++; if (dones !== 1) begin fails++; $display("FAIL hold_done_count: got %0d, expected 1", dones); end
      tests++; if (first_done !== LAT) begin fails++; $display("FAIL hold_latency: got %0d, expected %0d", first_done, LAT); end
      tests++; if (errs !== 0) begin fails++; $display("FAIL hold_err: got %0d pulses, expected 0", errs); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL hold_busy_after: got %b, expected 0", busy); end
      nerr = frame_errors(first);
      tests++; if (nerr !== 0) begin fails++; $display("FAIL hold_frame: %0d bad elements, first %0d", nerr, first); end
   endtask

   task automatic test_back_to_back();
      int lat, nerr, first;
      random_frame();
      compute_model(2, 1'b1);
      load_frame();
      stage    = LOGN'(2);
      scale_en = 1'b1;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = -1;
      for (int e = 1; e <= 40 && lat < 0; e++) begin
         @(posedge clk);
         #1;
         if (done) lat = e;
      end
      tests++; if (lat !== LAT) begin fails++; $display("FAIL b2b_first_latency: got %0d, expected %0d", lat, LAT); end
      nerr = frame_errors(first);
      tests++; if (nerr !== 0) begin fails++; $display("FAIL b2b_first_frame: %0d bad elements, first %0d", nerr, first); end
      random_frame();
      compute_model(3, 1'b0);
      load_frame();
      stage    = LOGN'(3);
      scale_en = 1'b0;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept: busy got %b, expected 1", busy); end
      lat = -1;
      for (int e = 1; e <= 40 && lat < 0; e++) begin
         @(posedge clk);
         #1;
         if (done) lat = e;
      end
      tests++; if (lat !== LAT) begin fails++; $display("FAIL b2b_second_latency: got %0d, expected %0d", lat, LAT); end
      nerr = frame_errors(first);
      tests++; if (nerr !== 0) begin fails++; $display("FAIL b2b_second_frame: %0d bad elements, first %0d", nerr, first); end
   endtask

   task automatic test_reset_mid();
      int lat, nerr, first;
      logic [P*KW-1:0] tw0;
      logic busy0;
      random_frame();
      load_frame();
      stage    = LOGN'(0);
      scale_en = 1'b0;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL midreset_flags: busy=%b done=%b, expected 0 0", busy, done); end
      tests++; if (dout !== '0) begin fails++; $display("FAIL midreset_dout: got nonzero frame, expected 0"); end
      tests++; if (tw_addr !== '0) begin fails++; $display("FAIL midreset_tw_addr: got %h, expected 0", tw_addr); end
      reset = 1'b0;
      @(posedge clk);
      #1;
      tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL midreset_quiet: busy=%b done=%b, expected 0 0", busy, done); end
      random_frame();
      compute_model(2, 1'b1);
      run_stage(2, 1'b1, lat, tw0, busy0);
      tests++; if (lat !== LAT) begin fails++; $display("FAIL midreset_restart_latency: got %0d, expected %0d", lat, LAT); end
      nerr = frame_errors(first);
      tests++; if (nerr !== 0) begin fails++; $display("FAIL midreset_restart_frame: %0d bad elements, first %0d", nerr, first); end
   endtask

   task automatic test_error();
      logic [N*2*DW-1:0] dprev;
      for (int t = 0; t < 2; t++) begin
         dprev = dout;
         stage = (t == 0) ? LOGN'(5) : LOGN'($urandom_range(5, 31));
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         tests++; if (err !== 1'b1) begin fails++; $display("FAIL error_pulse stage=%0d: got %b, expected 1", stage, err); end
         tests++; if (busy !== 1'b0) begin fails++; $display("FAIL error_busy stage=%0d: got %b, expected 0", stage, busy); end
         tests++; if (dout !== dprev) begin fails++; $display("FAIL error_dout stage=%0d: frame changed, expected unchanged", stage); end
         @(posedge clk);
         #1;
         tests++; if (err !== 1'b0) begin fails++; $display("FAIL error_one_cycle stage=%0d: got %b, expected 0", stage, err); end
      end
   endtask

   initial begin
      for (int k = 0; k < N / 2; k++) begin
         rom_re[k] = int'(16384.0 * $cos(2.0 * 3.141592653589793 * k / N));
         rom_im[k] = int'(-16384.0 * $sin(2.0 * 3.141592653589793 * k / N));
      end
      start    = 1'b0;
      stage    = '0;
      scale_en = 1'b0;
      din      = '0;
      test_reset();
      test_basic(1'b0);
      test_basic(1'b1);
      test_saturation();
      test_twiddle();
      test_random();
      test_hold_start();
      test_back_to_back();
      test_reset_mid();
      test_error();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fft_stage_seq.md
Name: fft_stage_seq

Overview:
- Parametrised radix-2 DIT FFT stage engine. Computes one complete butterfly stage over an N-point complex fixed-point frame using P parallel butterfly lanes.
- Time-multiplexes the lanes over N/(2P) issue cycles, with a start/busy/done handshake.
- Generalises the fixed 32-point, 4-lane, stage-0-only (±1 weights) design to:
  - any stage index;
  - twiddle multiplication from an external ROM;
  - optional per-stage scaling and saturation;
  - registered outputs.
- Sits between the frame buffer and the next stage instance; the chained instances form a full FFT.

Parameters:
- N, 32, points per frame; power of two, ≥ 4.
- P, 4, parallel butterfly lanes; power of two, divides N/2.
- DW, 16, bits per real/imag component (signed two's complement).
- FRAC, 14, fractional bits of the twiddle; 1.0 = 2^FRAC.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- stage  in  clog2(N)  stage index s; sampled with start.
- scale_en  in  1  halve results (round) this stage; sampled with start.
- din  in  N*2*DW  frame; element i at [i*2DW +: 2DW] = {re, im}.
- busy  out  1  high while a stage is in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse: start with stage ≥ log2N.
- dout  out  N*2*DW  result frame, same packing; holds until the next completed stage.
- tw_addr  out  P*(log2N-1)  per-lane twiddle index k.
- tw_data  in  P*2*DW  per-lane {re, im} of W_N^k; valid exactly one cycle after tw_addr.

Behaviour:
- Reset values: busy=0, done=0, err=0, dout=0, tw_addr=0; FSM in IDLE; internal buffer cleared.
- FSM states: IDLE → RUN → DRAIN → IDLE.
- IDLE:
  - start=1 and stage<log2N: latch din into the internal buffer; latch stage and scale_en; busy=1; go to RUN.
  - start=1 and stage≥log2N: err=1 for one cycle; stay in IDLE.
- RUN, C = N/(2P) issue cycles, issue counter c = 0..C-1. In cycle c, lane p takes butterfly b = c*P+p:
  - h = 2^s, j = b & (h-1);
  - i0 = (b>>s)*2h + j, i1 = i0+h;
  - k = j << (log2N-1-s).
  - tw_addr lane p = k; lane p's operands are registered.
- Lane pipeline (2 stages):
  - Stage 1: tw_data arrives; t = x[i1]*W, each component = (sum of DW×DW products + 2^(FRAC-1)) >>> FRAC (arithmetic, full-width intermediate).
  - Stage 2: y0 = x[i0]+t, y1 = x[i0]-t in DW+1 bits.
    - If scale_en: (v+1)>>>1.
    - Saturate to [-2^(DW-1), 2^(DW-1)-1].
    - Write back in place to buffer[i0], buffer[i1].
- DRAIN: 2 cycles after the last issue.
  - The last write-back occurs at the (C+2)th rising edge after the start-sampling edge.
  - On that same edge: dout ← final buffer, done=1, busy=0; FSM returns to IDLE.
  - N=32, P=4: done is high in the cycle after edge 6.
- Latency is fixed, independent of data.
- Hazards: each index is touched by exactly one butterfly per stage, so there are no read-after-write hazards.
- start while busy: ignored, no err.
- start in the same cycle done is high: accepted; a back-to-back stage is legal.
- Reset mid-operation: abort; all outputs return to reset values; any partial result is discarded.
- Twiddle k=0 passes through the multiplier unchanged: tw_data = (2^FRAC, 0) gives t = x[i1] exactly.

Decomposition:
- Package fft_pkg:
  - clog2-based LOGN constant function;
  - complex struct {re, im} of DW;
  - round-shift and saturate functions;
  - index-generation function (b, s → i0, i1, k).
- Sub-module fft_bfly_lane: the 2-stage complex butterfly (multiply, add/sub, scale, saturate), instantiated P times.
- The top level holds the FSM, issue counter, buffer, and read/write-back muxing.

Test Plan:
- Basic stage 0: s=0, x[0]=(1000,0), x[1]=(200,0), rest 0, twiddle ROM model (k=0→(16384,0)) → dout[0]=(1200,0), dout[1]=(800,0), rest 0; done 6 edges after start.
- Scaling: same stimulus with scale_en=1 → dout[0]=(600,0), dout[1]=(400,0).
- Saturation: s=0, x[0]=x[1]=(32767,0) → dout[0]=(32767,0), dout[1]=(0,0); x[0]=x[1]=(-32768,0) → dout[0]=(-32768,0).
- Twiddled last stage: s=4, x[16]=(1000,0), x[17]=(1000,0), ROM k=1→(16069,-3196) → dout[0]=(1000,0), dout[16]=(-1000,0), dout[1]=(981,-195), dout[17]=(-981,195); tw_addr lanes in cycle 0 = {3,2,1,0} (lane3..lane0).
- Handshake: start held high during busy → no second run, no err; start pulsed in the done cycle → second run completes 6 edges later. Reset asserted in the 2nd RUN cycle → busy=done=0 and dout=0 next cycle; a fresh start then produces correct results.
- Error: start with s=5 → err high for 1 cycle, busy stays 0, dout unchanged.
